// File: rtl/alu_exec_pkg.sv
// Shared encodings for the ALU execute stage: ALU control codes, main-control
// aluop classes and the R-type funct values the decoder recognises.
package alu_exec_pkg;

  localparam logic [2:0] GOUT_AND = 3'b000;
  localparam logic [2:0] GOUT_OR  = 3'b001;
  localparam logic [2:0] GOUT_ADD = 3'b010;
  localparam logic [2:0] GOUT_NOR = 3'b100;
  localparam logic [2:0] GOUT_SUB = 3'b110;
  localparam logic [2:0] GOUT_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/add32.sv
// Plain 32-bit adder, wrapping modulo 2^32 with no carry-out.
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU control decode, ALU datapath, PC adders and {n,z,v} flags.
// Optional NOR operation enabled by defining ALU_NOR_EN.
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter logic [31:0] PC_INC = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  aluop,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [31:0] br_off,
  input  logic        flag_we,
  output logic [31:0] result,
  output logic        zero,
  output logic [2:0]  gout,
  output logic [31:0] pc_plus4,
  output logic [31:0] br_target,
  output logic [2:0]  flags_q
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        v_add;
  logic        v_sub;
  logic        v;

  always_comb begin
    gout = GOUT_ADD;
    if (aluop == ALUOP_SUB) begin
      gout = GOUT_SUB;
    end else if (aluop[1]) begin
      case (funct)
        FUNCT_ADD: gout = GOUT_ADD;
        FUNCT_SUB: gout = GOUT_SUB;
        FUNCT_AND: gout = GOUT_AND;
        FUNCT_OR:  gout = GOUT_OR;
        FUNCT_SLT: gout = GOUT_SLT;
`ifdef ALU_NOR_EN
        FUNCT_NOR: gout = GOUT_NOR;
`endif
        default:   gout = GOUT_ADD;
      endcase
    end
  end

  assign sum  = a + b;
  assign diff = a - b;
  // Overflow when operands (b inverted for subtract) agree in sign but the result does not.
  assign v_add = (a[31] == b[31]) && (sum[31] != a[31]);
  assign v_sub = (a[31] != b[31]) && (diff[31] != a[31]);

  always_comb begin
    result = 32'd0;
    v      = 1'b0;
    case (gout)
      GOUT_AND: result = a & b;
      GOUT_OR:  result = a | b;
      GOUT_ADD: begin
        result = sum;
        v      = v_add;
      end
      GOUT_SUB: begin
        result = diff;
        v      = v_sub;
      end
      GOUT_SLT: begin
        // Sign of the true difference is diff[31] corrected by overflow.
        result = {31'd0, diff[31] ^ v_sub};
        v      = v_sub;
      end
`ifdef ALU_NOR_EN
      GOUT_NOR: result = ~(a | b);
`endif
      default:  result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

  add32 u_add_pc (
    .a   (pc),
    .b   (PC_INC),
    .sum (pc_plus4)
  );

  add32 u_add_br (
    .a   (pc_plus4),
    .b   (br_off),
    .sum (br_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else if (flag_we) begin
      flags_q <= {result[31], zero, v};
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus randomized checks of alu_exec_unit against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] a, b, pc, br_off;
  logic        flag_we;
  logic [31:0] result, pc_plus4, br_target;
  logic        zero;
  logic [2:0]  gout, flags_q;

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_flags;

  alu_exec_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .aluop     (aluop),
    .funct     (funct),
    .a         (a),
    .b         (b),
    .pc        (pc),
    .br_off    (br_off),
    .flag_we   (flag_we),
    .result    (result),
    .zero      (zero),
    .gout      (gout),
    .pc_plus4  (pc_plus4),
    .br_target (br_target),
    .flags_q   (flags_q)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] m_gout(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 3'b010;
    if (op == 2'b01) return 3'b110;
    case (f)
      6'h20: return 3'b010;
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2A: return 3'b111;
`ifdef ALU_NOR_EN
      6'h27: return 3'b100;
`endif
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [31:0] m_result(input logic [2:0] g, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    case (g)
      3'b000: return x & y;
      3'b001: return x | y;
      3'b010: return 32'(sx + sy);
      3'b110: return 32'(sx - sy);
      3'b111: return (sx < sy) ? 32'd1 : 32'd0;
`ifdef ALU_NOR_EN
      3'b100: return ~(x | y);
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_v(input logic [2:0] g, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint r;
    if (g == 3'b010) r = sx + sy;
    else if (g == 3'b110 || g == 3'b111) r = sx - sy;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
    aluop = op; funct = f; a = x; b = y;
  endtask

  task automatic chk_alu(input string tag);
    logic [2:0]  g;
    logic [31:0] r;
    #1;
    g = m_gout(aluop, funct);
    r = m_result(g, a, b);
    chk({tag, "_gout"}, 32'(gout), 32'(g));
    chk({tag, "_result"}, result, r);
    chk({tag, "_zero"}, 32'(zero), 32'(r == 32'd0));
  endtask

  task automatic clock_flags(input string tag);
    logic [2:0]  g;
    logic [31:0] r;
    g = m_gout(aluop, funct);
    r = m_result(g, a, b);
    @(posedge clk);
    if (flag_we) exp_flags = {r[31], r == 32'd0, m_v(g, a, b)};
    #1;
    chk({tag, "_flags"}, 32'(flags_q), 32'(exp_flags));
    @(negedge clk);
  endtask

  initial begin
    logic [5:0] fsel [7];
    fsel[0] = 6'h20; fsel[1] = 6'h22; fsel[2] = 6'h24; fsel[3] = 6'h25;
    fsel[4] = 6'h2A; fsel[5] = 6'h27; fsel[6] = 6'h00;

    rst_n = 1'b0; flag_we = 1'b0; pc = 32'd0; br_off = 32'd0;
    drive(2'b00, 6'h00, 32'd0, 32'd0);
    exp_flags = 3'b000;
    #3;
    chk("reset_flags", 32'(flags_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(2'b10, 6'h20, 32'd5, 32'd7);
    chk_alu("add_5_7");
    chk("add_5_7_abs", result, 32'd12);
    chk("add_5_7_gabs", 32'(gout), 32'(3'b010));

    drive(2'b01, 6'h2A, 32'h1234, 32'h1234);
    chk_alu("sub_zero");
    chk("sub_zero_abs", 32'(zero), 32'd1);
    flag_we = 1'b1;
    clock_flags("sub_zero");
    chk("sub_zero_fabs", 32'(flags_q), 32'(3'b010));

    drive(2'b10, 6'h20, 32'h7FFFFFFF, 32'd1);
    chk_alu("ovf");
    chk("ovf_abs", result, 32'h80000000);
    clock_flags("ovf");
    chk("ovf_fabs", 32'(flags_q), 32'(3'b101));

    flag_we = 1'b0;
    drive(2'b00, 6'h00, 32'd0, 32'd0);
    clock_flags("hold");
    chk("hold_abs", 32'(flags_q), 32'(3'b101));

    drive(2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1);
    chk_alu("slt_neg1");
    chk("slt_neg1_abs", result, 32'd1);
    drive(2'b11, 6'h2A, 32'h80000000, 32'd1);
    chk_alu("slt_ovf");
    chk("slt_ovf_abs", result, 32'd1);
    drive(2'b10, 6'h2A, 32'd3, 32'd2);
    chk_alu("slt_3_2");
    chk("slt_3_2_abs", result, 32'd0);

    pc = 32'h1C; br_off = 32'hFFFFFFF0;
    #1;
    chk("pc_plus4", pc_plus4, 32'h20);
    chk("br_target", br_target, 32'h10);
    pc = 32'hFFFFFFFC;
    #1;
    chk("pc_wrap", pc_plus4, 32'd0);

    // Reset between edges, then capture only on first flag_we edge.
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_flags", 32'(flags_q), 32'd0);
    exp_flags = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b10, 6'h20, 32'h7FFFFFFF, 32'd1);
    flag_we = 1'b0;
    clock_flags("post_reset_hold");
    flag_we = 1'b1;
    clock_flags("post_reset_cap");
    flag_we = 1'b0;

    drive(2'b10, 6'h27, 32'd0, 32'd0);
    chk_alu("nor");
`ifdef ALU_NOR_EN
    chk("nor_abs", result, 32'hFFFFFFFF);
`else
    chk("nor_abs", result, 32'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      if ($urandom_range(0, 7) == 0) x = 32'h80000000;
      if ($urandom_range(0, 7) == 0) y = 32'h7FFFFFFF;
      drive(2'($urandom_range(0, 3)), fsel[$urandom_range(0, 6)], x, y);
      if (funct == 6'h00) funct = 6'($urandom);
      pc = $urandom; br_off = $urandom;
      flag_we = 1'($urandom_range(0, 1));
      chk_alu("rand");
      chk("rand_pc4", pc_plus4, pc + 32'd4);
      chk("rand_br", br_target, pc + 32'd4 + br_off);
      clock_flags("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
